// File: rtl/var_decider_if.sv
// var_decider_if: request/result handshake and variable-table port bundle.
// master: var_decider side. slave: solver control plus table side.
//   start, imp_valid, imp_var, imp_val : requests from solver/propagation
//   ready, done, res_var, res_val,
//   conflict, all_assigned              : status back to solver control
//   tbl_en, tbl_r_w, tbl_address,
//   tbl_din, tbl_dout                   : single read/write table port
interface var_decider_if #(
    parameter int VAR_NUM = 8,
    parameter int IDX_W   = 3
);
    logic               start;
    logic               imp_valid;
    logic [IDX_W-1:0]   imp_var;
    logic               imp_val;
    logic               ready;
    logic               done;
    logic [IDX_W-1:0]   res_var;
    logic               res_val;
    logic               conflict;
    logic               all_assigned;
    logic               tbl_en;
    logic               tbl_r_w;
    logic [1:0]         tbl_address;
    logic [VAR_NUM-1:0] tbl_din;
    logic [VAR_NUM-1:0] tbl_dout;

    modport master (
        input  start, imp_valid, imp_var, imp_val, tbl_dout,
        output ready, done, res_var, res_val, conflict, all_assigned,
        output tbl_en, tbl_r_w, tbl_address, tbl_din
    );

    modport slave (
        output start, imp_valid, imp_var, imp_val, tbl_dout,
        input  ready, done, res_var, res_val, conflict, all_assigned,
        input  tbl_en, tbl_r_w, tbl_address, tbl_din
    );
endinterface

// File: rtl/var_decider.sv
// var_decider: sequencer for the BCP variable table (decide / imply).
// Reads assignment, free and assigned rows, evaluates, writes them back.
//   clock, reset : single clock, synchronous active-high reset
//   bus          : var_decider_if.master (requests, status, table port)
// Build option: define VAR_DECIDER_PHASE_ONE_EN to make decisions assign
// value 1 instead of 0; implications are unaffected.
module var_decider #(
    parameter int VAR_NUM = 8,
    parameter int IDX_W   = 3
) (
    input  logic          clock,
    input  logic          reset,
    var_decider_if.master bus
);

`ifdef VAR_DECIDER_PHASE_ONE_EN
    localparam logic DEC_VAL = 1'b1;
`else
    localparam logic DEC_VAL = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, RD_FREE, RD_VAL, RD_ASD, CAP,
        EVAL, WR_VAL, WR_FREE, WR_ASD, DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               is_imp;
    logic [IDX_W-1:0]   cur_var;
    logic               cur_val;
    logic [VAR_NUM-1:0] free_row;
    logic [VAR_NUM-1:0] asg_row;
    logic [VAR_NUM-1:0] asd_row;
    logic [VAR_NUM-1:0] cand;
    logic [IDX_W-1:0]   low_idx;
    logic               eval_all;
    logic               eval_conf;
    logic               eval_skip;
    logic               eval_dec;
    logic [IDX_W-1:0]   sel_var;
    logic               sel_val;
    logic [VAR_NUM-1:0] sel_bit;
    logic               en_next;
    logic               rw_next;
    logic [1:0]         addr_next;
    logic [VAR_NUM-1:0] din_next;

    // Lowest unassigned free variable; scan downward so the last hit wins.
    always_comb begin
        cand    = free_row & ~asd_row;
        low_idx = '0;
        for (int i = VAR_NUM - 1; i >= 0; i--) begin
            if (cand[i]) begin
                low_idx = i[IDX_W-1:0];
            end
        end
    end

    // In EVAL a decision's variable is not latched yet, so the first write
    // takes it straight from the priority scan.
    always_comb begin
        eval_dec  = (state == EVAL) && !is_imp;
        eval_all  = eval_dec && (cand == '0);
        eval_conf = (state == EVAL) && is_imp && asd_row[cur_var]
                    && (asg_row[cur_var] != cur_val);
        eval_skip = eval_all
                    || ((state == EVAL) && is_imp && asd_row[cur_var]);
        sel_var   = eval_dec ? low_idx : cur_var;
        sel_val   = eval_dec ? DEC_VAL : cur_val;
        sel_bit   = {{(VAR_NUM-1){1'b0}}, 1'b1} << sel_var;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.imp_valid || bus.start) state_next = RD_FREE;
            RD_FREE: state_next = RD_VAL;
            RD_VAL:  state_next = RD_ASD;
            RD_ASD:  state_next = CAP;
            CAP:     state_next = EVAL;
            EVAL:    state_next = eval_skip ? DONE : WR_VAL;
            WR_VAL:  state_next = WR_FREE;
            WR_FREE: state_next = WR_ASD;
            WR_ASD:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Table port values for the coming state; registered below so the
    // port is driven by flops only.
    always_comb begin
        en_next   = 1'b0;
        rw_next   = 1'b0;
        addr_next = 2'd0;
        din_next  = '0;
        unique case (state_next)
            RD_FREE: begin
                en_next   = 1'b1;
                rw_next   = 1'b1;
                addr_next = 2'd1;
            end
            RD_VAL: begin
                en_next   = 1'b1;
                rw_next   = 1'b1;
                addr_next = 2'd0;
            end
            RD_ASD: begin
                en_next   = 1'b1;
                rw_next   = 1'b1;
                addr_next = 2'd2;
            end
            WR_VAL: begin
                en_next   = 1'b1;
                addr_next = 2'd0;
                din_next  = sel_val ? (asg_row | sel_bit)
                                    : (asg_row & ~sel_bit);
            end
            WR_FREE: begin
                en_next   = 1'b1;
                addr_next = 2'd1;
                din_next  = free_row & ~sel_bit;
            end
            WR_ASD: begin
                en_next   = 1'b1;
                addr_next = 2'd2;
                din_next  = asd_row | sel_bit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            bus.ready        <= 1'b1;
            bus.done         <= 1'b0;
            bus.conflict     <= 1'b0;
            bus.all_assigned <= 1'b0;
            bus.res_var      <= '0;
            bus.res_val      <= 1'b0;
            bus.tbl_en       <= 1'b0;
            bus.tbl_r_w      <= 1'b0;
            bus.tbl_address  <= 2'd0;
            bus.tbl_din      <= '0;
        end else begin
            state            <= state_next;
            bus.ready        <= (state_next == IDLE);
            bus.done         <= (state_next == DONE);
            bus.conflict     <= eval_conf;
            bus.all_assigned <= eval_all;
            bus.tbl_en       <= en_next;
            bus.tbl_r_w      <= rw_next;
            bus.tbl_address  <= addr_next;
            bus.tbl_din      <= din_next;
            // all-assigned leaves the previous result visible
            if ((state_next == DONE) && !eval_all) begin
                bus.res_var <= sel_var;
                bus.res_val <= sel_val;
            end
        end
    end

    // Rows arrive one cycle after each read is issued.
    always_ff @(posedge clock) begin
        if (reset) begin
            is_imp   <= 1'b0;
            cur_var  <= '0;
            cur_val  <= 1'b0;
            free_row <= '0;
            asg_row  <= '0;
            asd_row  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.imp_valid) begin
                        is_imp  <= 1'b1;
                        cur_var <= bus.imp_var;
                        cur_val <= bus.imp_val;
                    end else if (bus.start) begin
                        is_imp  <= 1'b0;
                    end
                end
                RD_VAL: free_row <= bus.tbl_dout;
                RD_ASD: asg_row  <= bus.tbl_dout;
                CAP:    asd_row  <= bus.tbl_dout;
                EVAL: begin
                    if (!is_imp) begin
                        cur_var <= low_idx;
                        cur_val <= DEC_VAL;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
